pulse_div_sel: RTL

//  Parametrised successor to the fixed 1 Hz/2 Hz pulse divider for the UPDN_COUNTER design.

---
 rtl/pulse_div_sel.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pulse_div_sel.sv
// Run-time selectable pulse divider: 50% duty O_CLK plus a one-cycle O_TICK on each rising edge.
// Optional macro PULSE_DIV_SYNC_EN adds I_SYNC, a synchronous phase restart.
module pulse_div_sel #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned DIV0  = 25_000_000,
    parameter int unsigned DIV1  = 12_500_000,
    parameter int unsigned DIV2  = 5_000_000,
    parameter int unsigned DIV3  = 2_500_000
) (
    input  logic       I_CLK,
    input  logic       I_RST,
    input  logic       I_EN,
    input  logic [1:0] I_SEL,
`ifdef PULSE_DIV_SYNC_EN
    input  logic       I_SYNC,
`endif
    output logic       O_CLK,
    output logic       O_TICK,
    output logic [1:0] O_SEL_ACT
);

    if (DIV0 == 0 || DIV1 == 0 || DIV2 == 0 || DIV3 == 0) begin : g_div_zero
        $error("pulse_div_sel: every DIVn must be at least 1");
    end
    if (((DIV0 - 1) >> CNT_W) != 0 || ((DIV1 - 1) >> CNT_W) != 0 ||
        ((DIV2 - 1) >> CNT_W) != 0 || ((DIV3 - 1) >> CNT_W) != 0) begin : g_cnt_w
        $error("pulse_div_sel: CNT_W too narrow for the largest DIVn-1");
    end

    localparam logic [CNT_W-1:0] LAST0 = CNT_W'(DIV0 - 1);
    localparam logic [CNT_W-1:0] LAST1 = CNT_W'(DIV1 - 1);
    localparam logic [CNT_W-1:0] LAST2 = CNT_W'(DIV2 - 1);
    localparam logic [CNT_W-1:0] LAST3 = CNT_W'(DIV3 - 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] last_cnt;
    logic             sync_req;

`ifdef PULSE_DIV_SYNC_EN
    assign sync_req = I_SYNC;
`else
    assign sync_req = 1'b0;
`endif

    always_comb begin
        last_cnt = LAST0;
        case (sel_q)
            2'd0:    last_cnt = LAST0;
            2'd1:    last_cnt = LAST1;
            2'd2:    last_cnt = LAST2;
            default: last_cnt = LAST3;
        endcase
    end

    // NOTE: every _d gets a default before any branch, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;
        sel_d   = sel_q;
        if (sync_req) begin
            count_d = '0;
            clk_d   = 1'b0;
            sel_d   = I_SEL;
            state_d = I_EN ? RUN : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (I_EN) begin
                        state_d = RUN;
                        count_d = '0;
                        sel_d   = I_SEL;
                    end
                end
                RUN: begin
                    // Rate select is only adopted here, at a half-period boundary.
                    if (I_EN) begin
                        if (count_q == last_cnt) begin
                            count_d = '0;
                            clk_d   = ~clk_q;
                            tick_d  = ~clk_q;
                            sel_d   = I_SEL;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q <= IDLE;
            count_q <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            sel_q   <= sel_d;
        end
    end

    assign O_CLK     = clk_q;
    assign O_TICK    = tick_q;
    assign O_SEL_ACT = sel_q;

endmodule
